// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single synchronous RAM: core port 0, loader/DMA port 1 with locked bursts.
// Define MEM_ARB_RR_EN for round-robin arbitration in IDLE; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BURST_MAX  = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0,
    input  logic                  WE0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [SIZE-1:0]       WDATA0,
    output logic                  GNT0,
    output logic                  RVALID0,
    output logic [SIZE-1:0]       RDATA0,
    output logic                  STALL0,
    input  logic                  REQ1,
    input  logic                  WE1,
    input  logic                  LOCK1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [SIZE-1:0]       WDATA1,
    output logic                  GNT1,
    output logic                  RVALID1,
    output logic [SIZE-1:0]       RDATA1,
    output logic                  MEM_EN,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [SIZE-1:0]       MEM_WDATA,
    input  logic [SIZE-1:0]       MEM_RDATA
);

    typedef enum logic [1:0] {IDLE, LOCKED1, YIELD} state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(BURST_MAX);

    state_t     state;
    logic [7:0] burst_cnt;
    logic [7:0] burst_inc;
    logic       rvalid0_p1;
    logic       rvalid1_p1;
    logic       idle_gnt0;
    logic       idle_gnt1;
    logic       gnt0;
    logic       gnt1;

`ifdef MEM_ARB_RR_EN
    // last_gnt = 1 means port 1 was granted last, so port 0 wins the next conflict.
    logic last_gnt;

    always_ff @(posedge CLK) begin
        if (RESET)
            last_gnt <= 1'b1;
        else if (gnt0 || gnt1)
            last_gnt <= gnt1;
    end

    assign idle_gnt0 = REQ0 & (~REQ1 | last_gnt);
    assign idle_gnt1 = REQ1 & (~REQ0 | ~last_gnt);
`else
    assign idle_gnt0 = REQ0;
    assign idle_gnt1 = REQ1 & ~REQ0;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RESET) begin
            case (state)
                IDLE: begin
                    gnt0 = idle_gnt0;
                    gnt1 = idle_gnt1;
                end
                LOCKED1: gnt1 = REQ1;
                YIELD:   gnt0 = REQ0;
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign burst_inc = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            burst_cnt  <= 8'd0;
            rvalid0_p1 <= 1'b0;
            rvalid1_p1 <= 1'b0;
        end else begin
            rvalid0_p1 <= gnt0 & ~WE0;
            rvalid1_p1 <= gnt1 & ~WE1;
            case (state)
                IDLE: begin
                    if (gnt1 && LOCK1) begin
                        burst_cnt <= 8'd1;
                        // A one-beat burst limit is already reached by the opening grant.
                        state     <= (BURST_LIMIT <= 8'd1) ? YIELD : LOCKED1;
                    end else begin
                        burst_cnt <= 8'd0;
                    end
                end
                LOCKED1: begin
                    if (!LOCK1 || !REQ1) begin
                        state     <= IDLE;
                        burst_cnt <= 8'd0;
                    end else begin
                        burst_cnt <= burst_inc;
                        if (burst_inc >= BURST_LIMIT)
                            state <= YIELD;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Read responses are masked during reset so an in-flight read is dropped.
    assign GNT0      = gnt0;
    assign GNT1      = gnt1;
    assign STALL0    = REQ0 & ~gnt0 & ~RESET;
    assign RVALID0   = rvalid0_p1 & ~RESET;
    assign RVALID1   = rvalid1_p1 & ~RESET;
    assign RDATA0    = RVALID0 ? MEM_RDATA : '0;
    assign RDATA1    = RVALID1 ? MEM_RDATA : '0;
    assign MEM_EN    = gnt0 | gnt1;
    assign MEM_WE    = gnt0 ? WE0 : (gnt1 ? WE1 : 1'b0);
    assign MEM_ADDR  = gnt0 ? ADDR0 : (gnt1 ? ADDR1 : '0);
    assign MEM_WDATA = gnt0 ? WDATA0 : (gnt1 ? WDATA1 : '0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM on the memory side.
// Expected grant patterns follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;

    localparam int SIZE = 32;
    localparam int AW   = 10;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic            REQ0 = 1'b0, WE0 = 1'b0;
    logic [AW-1:0]   ADDR0 = '0;
    logic [SIZE-1:0] WDATA0 = '0;
    logic            GNT0, RVALID0, STALL0;
    logic [SIZE-1:0] RDATA0;
    logic            REQ1 = 1'b0, WE1 = 1'b0, LOCK1 = 1'b0;
    logic [AW-1:0]   ADDR1 = '0;
    logic [SIZE-1:0] WDATA1 = '0;
    logic            GNT1, RVALID1;
    logic [SIZE-1:0] RDATA1;
    logic            MEM_EN, MEM_WE;
    logic [AW-1:0]   MEM_ADDR;
    logic [SIZE-1:0] MEM_WDATA;
    logic [SIZE-1:0] MEM_RDATA = '0;

    logic [SIZE-1:0] ram [0:(1<<AW)-1];

    int checks = 0;
    int fails  = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
            else        MEM_RDATA <= ram[MEM_ADDR];
        end
    end

    mem_arbiter #(.SIZE(SIZE), .ADDR_WIDTH(AW), .BURST_MAX(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0),
        .GNT0(GNT0), .RVALID0(RVALID0), .RDATA0(RDATA0), .STALL0(STALL0),
        .REQ1(REQ1), .WE1(WE1), .LOCK1(LOCK1), .ADDR1(ADDR1), .WDATA1(WDATA1),
        .GNT1(GNT1), .RVALID1(RVALID1), .RDATA1(RDATA1),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        REQ0 = 1'b0; WE0 = 1'b0; REQ1 = 1'b0; WE1 = 1'b0; LOCK1 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        next_cycle();
        next_cycle();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1;
        @(negedge CLK);
        checks++; if (GNT0 !== 1'b0)   begin fails++; $display("FAIL reset_gnt0 got %b want 0", GNT0); end
        checks++; if (GNT1 !== 1'b0)   begin fails++; $display("FAIL reset_gnt1 got %b want 0", GNT1); end
        checks++; if (MEM_EN !== 1'b0) begin fails++; $display("FAIL reset_mem_en got %b want 0", MEM_EN); end
        checks++; if (MEM_WE !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b want 0", MEM_WE); end
        checks++; if (STALL0 !== 1'b0) begin fails++; $display("FAIL reset_stall0 got %b want 0", STALL0); end
        next_cycle();
        @(negedge CLK);
        checks++; if (RVALID0 !== 1'b0) begin fails++; $display("FAIL reset_rvalid0 got %b want 0", RVALID0); end
        checks++; if (RVALID1 !== 1'b0) begin fails++; $display("FAIL reset_rvalid1 got %b want 0", RVALID1); end
        idle_inputs();
        next_cycle();
        RESET = 1'b0;
        next_cycle();
    endtask

    task automatic test_read0();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 10'h010;
        @(negedge CLK);
        checks++; if (GNT0 !== 1'b1)       begin fails++; $display("FAIL read0_gnt0 got %b want 1", GNT0); end
        checks++; if (MEM_EN !== 1'b1)     begin fails++; $display("FAIL read0_mem_en got %b want 1", MEM_EN); end
        checks++; if (MEM_WE !== 1'b0)     begin fails++; $display("FAIL read0_mem_we got %b want 0", MEM_WE); end
        checks++; if (MEM_ADDR !== 10'h010) begin fails++; $display("FAIL read0_mem_addr got %h want 010", MEM_ADDR); end
        checks++; if (STALL0 !== 1'b0)     begin fails++; $display("FAIL read0_stall0 got %b want 0", STALL0); end
        next_cycle();
        REQ0 = 1'b0;
        @(negedge CLK);
        checks++; if (RVALID0 !== 1'b1)          begin fails++; $display("FAIL read0_rvalid0 got %b want 1", RVALID0); end
        checks++; if (RDATA0 !== 32'hDEADBEEF)   begin fails++; $display("FAIL read0_rdata0 got %h want deadbeef", RDATA0); end
        checks++; if (RVALID1 !== 1'b0)          begin fails++; $display("FAIL read0_rvalid1 got %b want 0", RVALID1); end
        checks++; if (RDATA1 !== 32'h0)          begin fails++; $display("FAIL read0_rdata1 got %h want 0", RDATA1); end
        next_cycle();
        @(negedge CLK);
        checks++; if (RVALID0 !== 1'b0) begin fails++; $display("FAIL read0_rvalid0_clear got %b want 0", RVALID0); end
        checks++; if (RDATA0 !== 32'h0) begin fails++; $display("FAIL read0_rdata0_clear got %h want 0", RDATA0); end
        next_cycle();
    endtask

    task automatic test_conflict();
        logic exp1;
        do_reset();
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 10'h020; WDATA0 = 32'h11;
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 10'h021; WDATA1 = 32'h22; LOCK1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp1 = (i % 2) == 1;
`else
            exp1 = 1'b0;
`endif
            @(negedge CLK);
            checks++; if (GNT0 !== ~exp1)  begin fails++; $display("FAIL conflict_gnt0[%0d] got %b want %b", i, GNT0, ~exp1); end
            checks++; if (GNT1 !== exp1)   begin fails++; $display("FAIL conflict_gnt1[%0d] got %b want %b", i, GNT1, exp1); end
            checks++; if (STALL0 !== exp1) begin fails++; $display("FAIL conflict_stall0[%0d] got %b want %b", i, STALL0, exp1); end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_lock_burst();
        logic e0, e1;
        REQ1 = 1'b1; LOCK1 = 1'b1; WE1 = 1'b1;
        REQ0 = 1'b0; WE0 = 1'b0; ADDR0 = 10'h010;
        for (int c = 1; c <= 10; c++) begin
            ADDR1 = 10'h200 + 10'(c);
            WDATA1 = 32'(c);
            if (c >= 2) REQ0 = 1'b1;
            if (c <= 8)      begin e0 = 1'b0; e1 = 1'b1; end
            else if (c == 9) begin e0 = 1'b1; e1 = 1'b0; end
            else begin
`ifdef MEM_ARB_RR_EN
                e0 = 1'b0; e1 = 1'b1;
`else
                e0 = 1'b1; e1 = 1'b0;
`endif
            end
            @(negedge CLK);
            checks++; if (GNT0 !== e0) begin fails++; $display("FAIL burst_gnt0[%0d] got %b want %b", c, GNT0, e0); end
            checks++; if (GNT1 !== e1) begin fails++; $display("FAIL burst_gnt1[%0d] got %b want %b", c, GNT1, e1); end
            if (c >= 2 && c <= 8) begin
                checks++; if (STALL0 !== 1'b1) begin fails++; $display("FAIL burst_stall0[%0d] got %b want 1", c, STALL0); end
            end
            if (c == 10) begin
                checks++; if (RVALID0 !== 1'b1)        begin fails++; $display("FAIL burst_yield_rvalid0 got %b want 1", RVALID0); end
                checks++; if (RDATA0 !== 32'hDEADBEEF) begin fails++; $display("FAIL burst_yield_rdata0 got %h want deadbeef", RDATA0); end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
        checks++; if (ram[10'h208] !== 32'd8) begin fails++; $display("FAIL burst_ram_208 got %h want 8", ram[10'h208]); end
    endtask

    task automatic test_lock_drop();
        logic [SIZE-1:0] want;
        int  n;
        bit  done;
        for (int i = 0; i < 3; i++) begin
            REQ1 = 1'b1; LOCK1 = 1'b1; WE1 = 1'b1;
            ADDR1 = 10'h100 + 10'(i); WDATA1 = 32'hA5A50000 + 32'(i);
            @(negedge CLK);
            checks++; if (GNT1 !== 1'b1) begin fails++; $display("FAIL drop_write_gnt1[%0d] got %b want 1", i, GNT1); end
            next_cycle();
        end
        REQ1 = 1'b0; LOCK1 = 1'b0; WE1 = 1'b0;
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 10'h100;
        @(negedge CLK);
        checks++; if (GNT0 !== 1'b0) begin fails++; $display("FAIL drop_locked_gnt0 got %b want 0", GNT0); end
        next_cycle();
        @(negedge CLK);
        checks++; if (GNT0 !== 1'b1) begin fails++; $display("FAIL drop_idle_gnt0 got %b want 1", GNT0); end
        next_cycle();
        REQ0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                REQ0 = 1'b1; ADDR0 = 10'h100 + 10'(i);
                next_cycle();
                REQ0 = 1'b0;
            end
            want = 32'hA5A50000 + 32'(i);
            @(negedge CLK);
            checks++; if (RDATA0 !== want) begin fails++; $display("FAIL drop_readback[%0d] got %h want %h", i, RDATA0, want); end
            next_cycle();
        end
        // A fresh locked burst must run the full length, showing the counter restarted.
        REQ1 = 1'b1; LOCK1 = 1'b1; WE1 = 1'b1; ADDR1 = 10'h300;
        n = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLK);
            if (GNT0) done = 1'b1;
            else if (GNT1) n++;
            next_cycle();
            REQ0 = 1'b1;
        end
        checks++; if (!done) begin fails++; $display("FAIL drop_burst_timeout got no yield want yield within 20 cycles"); end
        checks++; if (n != 8) begin fails++; $display("FAIL drop_burst_len got %0d want 8", n); end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_read();
        REQ0 = 1'b0; REQ1 = 1'b1; WE1 = 1'b0; LOCK1 = 1'b0; ADDR1 = 10'h100;
        @(negedge CLK);
        checks++; if (GNT1 !== 1'b1) begin fails++; $display("FAIL rstrd_gnt1 got %b want 1", GNT1); end
        next_cycle();
        RESET = 1'b1; REQ0 = 1'b1;
        @(negedge CLK);
        checks++; if (GNT0 !== 1'b0)    begin fails++; $display("FAIL rstrd_gnt0_in_reset got %b want 0", GNT0); end
        checks++; if (GNT1 !== 1'b0)    begin fails++; $display("FAIL rstrd_gnt1_in_reset got %b want 0", GNT1); end
        checks++; if (RVALID1 !== 1'b0) begin fails++; $display("FAIL rstrd_rvalid1_in_reset got %b want 0", RVALID1); end
        checks++; if (RDATA1 !== 32'h0) begin fails++; $display("FAIL rstrd_rdata1_in_reset got %h want 0", RDATA1); end
        checks++; if (MEM_EN !== 1'b0)  begin fails++; $display("FAIL rstrd_mem_en_in_reset got %b want 0", MEM_EN); end
        next_cycle();
        RESET = 1'b0;
        @(negedge CLK);
        checks++; if (RVALID1 !== 1'b0) begin fails++; $display("FAIL rstrd_rvalid1_after got %b want 0", RVALID1); end
        checks++; if (GNT0 !== 1'b1)    begin fails++; $display("FAIL rstrd_idle_gnt0 got %b want 1", GNT0); end
        checks++; if (GNT1 !== 1'b0)    begin fails++; $display("FAIL rstrd_idle_gnt1 got %b want 0", GNT1); end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        ram[10'h010] = 32'hDEADBEEF;
        test_reset();
        test_read0();
        test_conflict();
        test_lock_burst();
        test_lock_drop();
        test_reset_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 32, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word address width.
REQ-003 SHALL have parameter BURST_MAX, default 8, maximum consecutive locked grants to port 1 (range 1..255).
REQ-004 SHALL have ports: CLK in 1, single clock, all state updates on rising edge; RESET in 1, synchronous active-high reset.
REQ-005 SHALL have port 0 (core data port): REQ0 in 1, WE0 in 1, ADDR0 in ADDR_WIDTH, WDATA0 in SIZE, GNT0 out 1, RVALID0 out 1, RDATA0 out SIZE.
REQ-006 SHALL have port 1 (loader/DMA port): REQ1 in 1, WE1 in 1, LOCK1 in 1, ADDR1 in ADDR_WIDTH, WDATA1 in SIZE, GNT1 out 1, RVALID1 out 1, RDATA1 out SIZE.
REQ-007 SHALL have memory side: MEM_EN out 1, MEM_WE out 1, MEM_ADDR out ADDR_WIDTH, MEM_WDATA out SIZE, MEM_RDATA in SIZE (synchronous RAM, read data valid one cycle after MEM_EN with MEM_WE=0).
REQ-008 SHALL provide STALL0 out 1 = REQ0 & !GNT0, used to freeze the core PC.

Function
REQ-009 SHALL grant at most one port per cycle; GNT0/GNT1 combinational from current requests and registered state; GNT0 & GNT1 never both 1.
REQ-010 SHALL drive MEM_EN=GNT0|GNT1; MEM_WE, MEM_ADDR, MEM_WDATA taken from the granted port; MEM_WE=0 and MEM_ADDR/MEM_WDATA=0 when no grant.
REQ-011 A granted access SHALL complete in the grant cycle; writes need no response; a granted read SHALL assert RVALIDx exactly one cycle later with RDATAx=MEM_RDATA, only for the port that issued it.
REQ-012 RDATAx SHALL be 0 when RVALIDx=0.
REQ-013 SHALL implement FSM states IDLE, LOCKED1, YIELD.
REQ-014 IDLE: arbitration per the Configuration policy; if GNT1 with LOCK1=1 -> LOCKED1, burst counter loaded with 1.
REQ-015 LOCKED1: port 1 owns the memory; GNT1=REQ1, GNT0=0; counter increments per GNT1; LOCK1=0 or REQ1=0 -> IDLE; counter reaching BURST_MAX with LOCK1 still 1 -> YIELD.
REQ-016 YIELD: lasts exactly one cycle; port 0 has absolute priority (GNT0=REQ0, GNT1=0 even if REQ0=0); then -> IDLE.
REQ-017 Burst counter SHALL be 8 bits, saturating, cleared on every entry to IDLE.
REQ-018 Requesters SHALL hold REQx, WEx, ADDRx, WDATAx stable until GNTx; the arbiter SHALL NOT register or queue requests.
REQ-019 When REQ0 and REQ1 both drop, the FSM SHALL return to or remain in IDLE next cycle.

Reset
REQ-020 With RESET=1 at a rising edge: state=IDLE, counter=0, last-granted pointer=1 (port 0 favoured first), RVALID0=RVALID1=0, pending-read flags cleared.
REQ-021 While RESET=1, GNT0, GNT1, MEM_EN, MEM_WE, STALL0 SHALL be 0; a read granted in the cycle before reset SHALL NOT produce RVALID.

Configuration
REQ-022 Macro MEM_ARB_RR_EN defined: IDLE uses round-robin, the port not granted last wins on conflict; pointer updates on every grant.
REQ-023 Macro MEM_ARB_RR_EN undefined: IDLE uses fixed priority, port 0 wins every conflict; pointer logic absent; LOCKED1/YIELD unchanged.

Verification
REQ-024 Reset, then REQ0 read ADDR0=0x010, RAM[0x010]=0xDEADBEEF -> GNT0=1 same cycle, next cycle RVALID0=1, RDATA0=0xDEADBEEF, RVALID1=0.
REQ-025 REQ0 and REQ1 both held 4 cycles in IDLE with MEM_ARB_RR_EN -> grants 0,1,0,1; without macro -> 0,0,0,0 with STALL0=0 and GNT1=0 throughout.
REQ-026 Port 1 write burst LOCK1=1, BURST_MAX=8, REQ0 held -> GNT1 cycles 1..8, cycle 9 YIELD GNT0=1, cycle 10 IDLE arbitration.
REQ-027 Port 1 locked burst drops LOCK1 after 3 writes to 0x100..0x102 -> FSM IDLE next cycle, RAM holds the 3 words, counter=0.
REQ-028 RESET asserted in cycle after a port 1 read grant -> RVALID1 stays 0, GNT0=GNT1=0 during reset, state IDLE after release.
